// File: rtl/fdc_meas_ctrl.sv
// -----------------------------------------------------------------------------
// fdc_meas_ctrl
//
// Measurement sequencer for the FDC core. It holds the core in clear, then
// frames gate windows of WIN_LEN clk_ref periods. Each window starts on a
// reference edge. After each window the 5-bit core count is sampled, N_WIN
// samples are summed, and the sum is presented on a valid/ready port.
//
// clk_ref is asynchronous to clk. It passes through a 2-flop synchronizer.
// A third flop provides rising-edge detection.
//
// Build option:
//   FDC_CTRL_CONT_EN  When defined, the block runs in continuous mode. When a
//                     handshake completes while start is high, the controller
//                     loops straight back into CLEAR. The accumulator is
//                     cleared and the latched sel is kept. When undefined, the
//                     block is single-shot and always returns to IDLE.
//
// Parameters:
//   WIN_LEN  clk_ref rising edges per gate window (>=1)
//   N_WIN    windows summed per result (>=1)
//   ACC_W    result width, >= 5 + clog2(N_WIN)
//   TIMEOUT  max clk cycles between reference edges in ARM/MEASURE
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   start         measurement request, sampled in IDLE
//   sel           FDC range select, latched on an accepted start
//   clk_ref       asynchronous reference clock
//   fdc_out[4:0]  FDC count, unsigned
//   fdc_reset     clear to the FDC core, active-high
//   fdc_selec     latched sel
//   busy          high in every state except IDLE
//   result        sum of window samples
//   result_valid  result available
//   result_ready  consumer accepts the result
//   error         timeout flag, qualified by result_valid
// -----------------------------------------------------------------------------
module fdc_meas_ctrl #(
  parameter int WIN_LEN = 8,
  parameter int N_WIN   = 4,
  parameter int ACC_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sel,
  input  logic             clk_ref,
  input  logic [4:0]       fdc_out,
  output logic             fdc_reset,
  output logic             fdc_selec,
  output logic             busy,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             error
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;
  localparam logic [2:0] ST_SAMPLE  = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam int EC_W = $clog2(WIN_LEN + 1);
  localparam int WC_W = $clog2(N_WIN + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);

  localparam logic [EC_W-1:0] EDGE_LAST = EC_W'(WIN_LEN - 1);
  localparam logic [WC_W-1:0] N_WIN_C   = WC_W'(N_WIN);
  localparam logic [TC_W-1:0] TMO_C     = TC_W'(TIMEOUT);

  // Registers
  logic [2:0]       state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             sel_q, sel_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WC_W-1:0]  win_q, win_d;
  logic [EC_W-1:0]  edge_q, edge_d;
  logic [TC_W-1:0]  tmo_q, tmo_d;
  logic             ph_q, ph_d;          // cycle counter for the two-cycle CLEAR/SETTLE states
  logic [ACC_W-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             fdc_reset_q, fdc_reset_d;
  logic             busy_q, busy_d;

  logic             ref_rise;
  logic [ACC_W-1:0] acc_sum;
  logic [WC_W-1:0]  win_inc;
  logic [TC_W-1:0]  tmo_inc;

  assign ref_rise = sync2_q & ~sync3_q;
  assign acc_sum  = acc_q + ACC_W'(fdc_out);
  assign win_inc  = win_q + WC_W'(1);
  assign tmo_inc  = tmo_q + TC_W'(1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    acc_d    = acc_q;
    win_d    = win_q;
    edge_d   = edge_q;
    tmo_d    = tmo_q;
    ph_d     = ph_q;
    result_d = result_q;
    valid_d  = valid_q;
    error_d  = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = sel;
          acc_d   = '0;
          win_d   = '0;
          error_d = 1'b0;
          ph_d    = 1'b0;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        if (ph_q) begin
          ph_d    = 1'b0;
          tmo_d   = '0;
          state_d = ST_ARM;
        end else begin
          ph_d = 1'b1;
        end
      end

      ST_ARM: begin
        if (ref_rise) begin
          // Align the gate window to this reference edge.
          edge_d  = '0;
          tmo_d   = '0;
          state_d = ST_MEASURE;
        end else if (tmo_inc == TMO_C) begin
          // The reference has stalled. Report the partial sum.
          error_d  = 1'b1;
          result_d = acc_q;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ST_MEASURE: begin
        if (ref_rise) begin
          tmo_d = '0;
          if (edge_q == EDGE_LAST) begin
            ph_d    = 1'b0;
            state_d = ST_SETTLE;
          end else begin
            edge_d = edge_q + EC_W'(1);
          end
        end else if (tmo_inc == TMO_C) begin
          // The current window is abandoned and contributes nothing.
          error_d  = 1'b1;
          result_d = acc_q;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ST_SETTLE: begin
        if (ph_q) begin
          ph_d    = 1'b0;
          state_d = ST_SAMPLE;
        end else begin
          ph_d = 1'b1;
        end
      end

      ST_SAMPLE: begin
        acc_d = acc_sum;
        win_d = win_inc;
        if (win_inc < N_WIN_C) begin
          ph_d    = 1'b0;
          state_d = ST_CLEAR;
        end else begin
          result_d = acc_sum;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
`ifdef FDC_CTRL_CONT_EN
          // start behaves as a run level: keep looping while it is held.
          if (start) begin
            acc_d   = '0;
            win_d   = '0;
            error_d = 1'b0;
            ph_d    = 1'b0;
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The registered outputs follow the state being entered. This keeps them
    // aligned with the state register and free of input-to-output paths.
    fdc_reset_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      sel_q       <= 1'b0;
      acc_q       <= '0;
      win_q       <= '0;
      edge_q      <= '0;
      tmo_q       <= '0;
      ph_q        <= 1'b0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      fdc_reset_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= clk_ref;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      sel_q       <= sel_d;
      acc_q       <= acc_d;
      win_q       <= win_d;
      edge_q      <= edge_d;
      tmo_q       <= tmo_d;
      ph_q        <= ph_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      fdc_reset_q <= fdc_reset_d;
      busy_q      <= busy_d;
    end
  end

  assign fdc_reset    = fdc_reset_q;
  assign fdc_selec    = sel_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign error        = error_q;

endmodule
